fetch_queue: RTL and testbench

- Parametrised fetch stage for the pipelined core.
- Owns PCF and issues reads to a 1-cycle-latency instruction BRAM.
- Buffers returned words with their PCs in a DEPTH-entry queue, so a decode stall no longer freezes the BRAM address.
- Sits between the BRAM port and the decode register; the execute stage redirects it on a taken branch or jump and flushes everything in flight.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch stage.
//   FETCH_XLEN    : default address/instruction width
//   INSTR_NOP     : instruction presented to decode when nothing is valid
//   fetch_entry_t : one queue entry, the fetched word together with its PC
//   align_pc()    : forces a redirect target onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [FETCH_XLEN-1:0] align_pc(input logic [FETCH_XLEN-1:0] addr);
        return {addr[FETCH_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO of fetch_entry_t. The head entry is readable
// combinationally so decode sees it in the cycle it becomes valid.
// Ports:
//   clk         : clock
//   srst_i      : synchronous active-high reset, empties the FIFO
//   clear_i     : synchronous flush (redirect); wins over push and pop
//   push_i      : write push_data_i at the tail
//   push_data_i : entry to write
//   pop_i       : remove the head entry
//   head_o      : current head entry
//   valid_o     : FIFO holds at least one entry
//   count_o     : number of occupied entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          srst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i && !srst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Fetch stage: owns PCF, issues reads to a 1-cycle-latency instruction BRAM and
// buffers returned words with their PCs so a decode stall does not freeze the
// BRAM address. A taken branch/jump from execute flushes everything in flight
// and refetches from the target in the same cycle.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   RedirectE, PCTargetE : redirect request and target from execute
//   ReadyD               : decode accepts the head entry this cycle
//   ImemEn, ImemAddr     : BRAM read request
//   ImemRData            : BRAM data, valid the cycle after ImemEn
//   InstrValidD, InstrD, PCD, PCPlus4D : head entry presented to decode
//   CountQ               : occupied queue entries
// Optional feature (macro FETCH_BYPASS_EN): a response arriving at an empty
// queue is shown to decode combinationally, and if accepted is never written.
// XLEN must match fetch_pkg::FETCH_XLEN (the entry type is sized by it).
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RedirectE,
    input  logic [XLEN-1:0]            PCTargetE,
    input  logic                       ReadyD,
    output logic                       ImemEn,
    output logic [XLEN-1:0]            ImemAddr,
    input  logic [XLEN-1:0]            ImemRData,
    output logic                       InstrValidD,
    output logic [XLEN-1:0]            InstrD,
    output logic [XLEN-1:0]            PCD,
    output logic [XLEN-1:0]            PCPlus4D,
    output logic [$clog2(DEPTH+1)-1:0] CountQ
);

    localparam int            CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;   // PC of the read currently in flight
    logic            inflight_q, inflight_d;

    fetch_entry_t    fifo_head, fifo_wdata, sel_entry;
    logic            fifo_valid, fifo_push, fifo_pop;
    logic [CW-1:0]   fifo_count;

    logic [XLEN-1:0] target;
    logic            kill, resp_ok, bypass, pop, issue;
    logic [CW:0]     occupancy;

    assign target = align_pc(PCTargetE);

    // With a 1-cycle BRAM the only stale word is the one returning in the
    // redirect cycle itself; the read issued in that cycle is the target's.
    assign kill    = inflight_q & RedirectE;
    assign resp_ok = inflight_q & ~kill;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_ok & ~fifo_valid;
`else
    assign bypass = 1'b0;
`endif

    assign InstrValidD = ~reset & (fifo_valid | bypass);
    assign pop         = InstrValidD & ReadyD;

    // Credit check counts entries held plus the word on its way back, so a
    // push into a full queue is impossible.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    // A redirect always refetches: the queue and the stale word are discarded.
    assign issue     = ~reset & (RedirectE | (occupancy < DEPTH_LIM));

    assign ImemAddr = RedirectE ? target : pcf_q;
    assign ImemEn   = issue;

    assign fifo_wdata = '{pc: req_pc_q, instr: ImemRData};
    assign fifo_push  = resp_ok & ~(bypass & ReadyD);
    assign fifo_pop   = fifo_valid & ReadyD & ~RedirectE;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .srst_i      (reset),
        .clear_i     (RedirectE),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign sel_entry = bypass ? fifo_wdata : fifo_head;
    assign InstrD    = InstrValidD ? sel_entry.instr : INSTR_NOP;
    assign PCD       = sel_entry.pc;
    assign PCPlus4D  = PCD + XLEN'(4);
    assign CountQ    = fifo_count;

    always_comb begin
        pcf_d      = pcf_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        if (issue) begin
            pcf_d    = ImemAddr + XLEN'(4);
            req_pc_d = ImemAddr;
        end else if (RedirectE) begin
            pcf_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q      <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. The BRAM returns addr ^ 32'hA5A5_0000.
// The reference model is the architectural instruction stream: after reset or
// a redirect, decode must accept start, start+4, start+8, ... in order, each
// with instr = pc ^ mask. The stimulus side rebuilds that expected stream
// whenever it resets or redirects; a monitor pops and compares on every
// accepted transaction. Directed checks cover latency, fill/drain, redirect
// and reset-in-flight; a random phase follows.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH + 1);
    localparam logic [31:0] MASK     = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT    = 1;   // cycles from issue to decode
    localparam int STEADY = 0;   // occupancy in steady streaming
`else
    localparam int LAT    = 2;
    localparam int STEADY = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          RedirectE;
    logic [31:0]   PCTargetE;
    logic          ReadyD;
    logic          ImemEn;
    logic [31:0]   ImemAddr;
    logic [31:0]   ImemRData = '0;
    logic          InstrValidD;
    logic [31:0]   InstrD;
    logic [31:0]   PCD;
    logic [31:0]   PCPlus4D;
    logic [CW-1:0] CountQ;

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   next_pc;
    logic          pend = 1'b0;   // a BRAM read is returning this cycle
    int            stall_cnt = 0;
    logic [31:0]   e;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .RedirectE   (RedirectE),
        .PCTargetE   (PCTargetE),
        .ReadyD      (ReadyD),
        .ImemEn      (ImemEn),
        .ImemAddr    (ImemAddr),
        .ImemRData   (ImemRData),
        .InstrValidD (InstrValidD),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .CountQ      (CountQ)
    );

    // Instruction BRAM model, 1-cycle read latency.
    always @(posedge clk) begin
        if (ImemEn) ImemRData <= ImemAddr ^ MASK;
        pend <= ImemEn;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 32) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        next_pc = start;
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    // Holds reset for n cycles; returns 1 ns after the edge of the first
    // cycle with reset low.
    task automatic do_reset(input int n);
        reset     = 1'b1;
        RedirectE = 1'b0;
        ReadyD    = 1'b0;
        restart(RESET_PC);
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_count(input int target, input string name);
        for (int i = 0; i < 20 && int'(CountQ) != target; i++) tick();
        check(name, 32'(CountQ), 32'(target));
    endtask

    // Scoreboard monitor and per-cycle invariants.
    always @(negedge clk) begin
        if (reset) begin
            stall_cnt = 0;
            check("rst_en", 32'(ImemEn), 32'd0);
            check("rst_valid", 32'(InstrValidD), 32'd0);
        end else begin
            if (!InstrValidD) check("nop_when_invalid", InstrD, NOP);
            check("count_le_depth", 32'(int'(CountQ) <= DEPTH), 32'd1);
            // a returning word with a full queue and no pop would overflow
            check("no_overflow", 32'(pend && !RedirectE && int'(CountQ) == DEPTH
                                      && !(InstrValidD && ReadyD)), 32'd0);
            if (RedirectE) begin
                check("redir_addr", ImemAddr, PCTargetE & 32'hFFFF_FFFC);
                check("redir_en", 32'(ImemEn), 32'd1);
                stall_cnt = 0;
            end else if (InstrValidD && ReadyD) begin
                stall_cnt = 0;
                check("pcplus4", PCPlus4D, PCD + 32'd4);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard_empty: got pc %h, expected none", PCD);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn pc=%h instr=%h exp_pc=%h", PCD, InstrD, e);
                    check("txn_pc", PCD, e);
                    check("txn_instr", InstrD, e ^ MASK);
                end
            end else if (ReadyD && !InstrValidD) begin
                stall_cnt++;
                check("liveness", 32'(stall_cnt <= 4), 32'd1);
            end else begin
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issues;
        int r;
        logic [31:0] tgt;

        reset     = 1'b1;
        RedirectE = 1'b0;
        PCTargetE = '0;
        ReadyD    = 1'b0;
        restart(RESET_PC);
        repeat (3) tick();
        @(negedge clk);
        check("reset_count", 32'(CountQ), 32'd0);
        check("reset_instr", InstrD, NOP);
        check("reset_en", 32'(ImemEn), 32'd0);

        // Reset release, ReadyD held: sequential fetch, first valid after LAT.
        tick();
        reset  = 1'b0;
        ReadyD = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("seq_en", 32'(ImemEn), 32'd1);
            check("seq_addr", ImemAddr, 32'(4 * k));
            check("seq_valid", 32'(InstrValidD), 32'(k >= LAT));
            if (k == LAT) begin
                check("first_pc", PCD, 32'h0);
                check("first_instr", InstrD, 32'hA5A5_0000);
            end
            if (k >= 3) check("steady_count", 32'(CountQ), 32'(STEADY));
            tick();
        end

        // Decode stalled for 10 cycles: exactly DEPTH reads, queue full.
        do_reset(1);
        issues = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            issues += int'(ImemEn);
            tick();
        end
        @(negedge clk);
        check("fill_issues", 32'(issues), 32'(DEPTH));
        check("fill_count", 32'(CountQ), 32'(DEPTH));
        check("fill_en", 32'(ImemEn), 32'd0);
        // Drain with ReadyD held: one pop per cycle, occupancy constant.
        tick();
        ReadyD = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("full_stream_valid", 32'(InstrValidD), 32'd1);
            if (k >= 1) check("full_stream_count", 32'(CountQ), 32'(DEPTH - 1));
            tick();
        end

        // Redirect while three entries are held and a word is returning.
        do_reset(1);
        wait_count(3, "pre_redir_count");
        check("pre_redir_pending", 32'(pend), 32'd1);
        RedirectE = 1'b1;
        PCTargetE = 32'h0000_0102;
        ReadyD    = 1'b1;
        restart(32'h0000_0100);
        @(negedge clk);
        check("redir_issue_addr", ImemAddr, 32'h0000_0100);
        tick();
        RedirectE = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) check("redir_cleared", 32'(CountQ), 32'd0);
            check("redir_valid", 32'(InstrValidD), 32'(k >= LAT));
            if (k == LAT) check("redir_first_pc", PCD, 32'h0000_0100);
            tick();
        end

        // Reset while two entries are held and a read is outstanding.
        do_reset(1);
        wait_count(2, "pre_rst_count");
        check("pre_rst_pending", 32'(pend), 32'd1);
        reset = 1'b1;
        restart(RESET_PC);
        @(negedge clk);
        check("midrst_valid", 32'(InstrValidD), 32'd0);
        check("midrst_instr", InstrD, NOP);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_count", 32'(CountQ), 32'd0);
        check("midrst_addr", ImemAddr, RESET_PC);
        check("midrst_en", 32'(ImemEn), 32'd1);
        tick();

        // Random phase: stalls, redirects (some near the top of the address
        // space to exercise wrap-around) and occasional resets.
        for (int c = 0; c < 400; c++) begin
            ReadyD = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset     = 1'b1;
                RedirectE = 1'b0;
                restart(RESET_PC);
            end else if (r < 8) begin
                reset = 1'b0;
                if ($urandom_range(0, 2) == 0) tgt = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
                else tgt = $urandom;
                RedirectE = 1'b1;
                PCTargetE = tgt;
                restart(tgt & 32'hFFFF_FFFC);
            end else begin
                reset     = 1'b0;
                RedirectE = 1'b0;
            end
            tick();
        end

        reset     = 1'b0;
        RedirectE = 1'b0;
        ReadyD    = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
